fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// - Upstream fetch stage of the nic8 CPU: owns the program counter (PC), the instruction register (IR) and the
//   FETCH/EXEC phase. Drives the 8-bit opcode into the control decoder and consumes the decoder's loadBarIR,
//   assertBarRom and doJump.
// - In FETCH it presents opcode 8'h00 (dest=IR, source=ROM), so the decoder itself performs the fetch.
// - Also keeps a sticky halt flag (jump-to-self) and a retired-instruction counter for debug.
// PARAMETERS
// - PC_WIDTH    8      width of PC and ROM address.
// - RESET_PC    0      PC value after reset.
// - CNT_WIDTH   16     width of the retired-instruction counter.
// PORTS
// - clk         in   1         system clock; all state updates on rising edge.
// - reset       in   1         asynchronous, active-high reset.
// - bus         in   8         data bus value in the current cycle.
// - loadBarIR   in   1         from decoder; low = IR loads from bus this edge.
// - assertBarRom in  1         from decoder; low = ROM drives bus from address pc.
// - doJump      in   1         from decoder; high = PC loads from bus this edge.
// - ir          out  8         opcode to decoder: 8'h00 in FETCH, IR register in EXEC.
// - pc          out  PC_WIDTH  ROM address.
// - phaseExec   out  1         0 = FETCH, 1 = EXEC.
// - halted      out  1         sticky; jump-to-self detected.
// - instrCount  out  CNT_WIDTH retired instructions, saturating.
// BEHAVIOUR
// - Reset (async, immediate): pc=RESET_PC, irReg=8'h00, phaseExec=0, instrAddr=RESET_PC, halted=0, instrCount=0.
//   Reset asserted mid-instruction aborts it; no partial update survives.
// - States:
//   - FETCH: ir output = 8'h00.
//   - EXEC: ir output = irReg.
// - Every edge, in priority order:
//   1. halted=1: pc, irReg, phase and instrCount hold. Nothing but reset clears it.
//   2. loadBarIR=0: irReg<=bus; instrAddr<=pc; phase<=EXEC; pc<=pc+1 (the fetched byte is consumed).
//      Applies in FETCH and also in EXEC when irReg=8'h00 (chained fetch).
//   3. Otherwise, if in EXEC: phase<=FETCH and instrCount increments (saturates at all-ones). Within the same edge:
//      - doJump=1: pc<=bus[PC_WIDTH-1:0]. The jump has priority over the increment even when the ROM supplies the
//        target.
//      - doJump=0 and assertBarRom=0: pc<=pc+1 (immediate operand consumed).
//      - otherwise: pc holds.
// - Halt: set on an EXEC edge where doJump=1 and bus==instrAddr. On that edge, pc<=bus and instrCount
//   increments, then everything freezes.
// - Arithmetic:
//   - pc increments modulo 2^PC_WIDTH; 0xFF+1 wraps to 0x00.
//   - bus bits above PC_WIDTH are ignored.
//   - instrCount never wraps.
// - Latency: each instruction takes exactly 2 cycles (FETCH + EXEC). A chained 8'h00 opcode adds one EXEC cycle per
//   repeat.
// - Illegal combination: doJump=1 together with loadBarIR=0 cannot come from the decoder (dest fields differ).
//   If it occurs, rule 2 wins and doJump is ignored.
// STRUCTURE
// - Shared package nic8_pkg:
//   - FETCH_OPCODE = 8'h00
//   - localparams for the phase encoding (PH_FETCH=1'b0, PH_EXEC=1'b1)
//   - DEST_IR/SRC_ROM field constants, shared with the decoder
// - One sub-module, pc_counter: loadable, enable-able, wrapping PC_WIDTH counter with async reset. The halt,
//   phase and counter logic live in fetch_sequencer.
// TESTING
// - Reset and fetch:
//   - Stimulus: reset, then bus=8'h42 with loadBarIR driven low in FETCH.
//   - Required: ir out=00 in FETCH; then irReg=42, pc=01, phaseExec=1.
// - Immediate:
//   - Stimulus: EXEC with assertBarRom=0, doJump=0.
//   - Required: pc 01->02, phaseExec=0, instrCount=1.
// - Jump:
//   - Stimulus: EXEC with doJump=1, bus=8'h80.
//   - Required: pc=80, not 81; phaseExec=0.
// - Halt:
//   - Stimulus: instruction at 0x10; EXEC with doJump=1, bus=8'h10.
//   - Required: halted=1; pc, instrCount and phaseExec then frozen for 10 cycles.
// - Wrap and chain:
//   - Stimulus: pc=FF, fetch.
//   - Required: pc=00.
//   - Stimulus: irReg=00 in EXEC with loadBarIR=0.
//   - Required: stays EXEC; instrCount unchanged.
// - Async reset mid-EXEC:
//   - Stimulus: assert reset between edges.
//   - Required: all outputs go to reset values before the next edge.

Source files
------------

// File: rtl/nic8_pkg.sv
// nic8_pkg: constants shared by the nic8 fetch sequencer and the control decoder.
//   FETCH_OPCODE    opcode presented to the decoder while fetching (dest=IR, source=ROM)
//   PH_FETCH/EXEC   encoding of the phaseExec output
//   DEST_IR/SRC_ROM decoder field codes that together form FETCH_OPCODE
package nic8_pkg;

    localparam logic [7:0] FETCH_OPCODE = 8'h00;

    localparam logic PH_FETCH = 1'b0;
    localparam logic PH_EXEC  = 1'b1;

    // Field codes used by the decoder; FETCH_OPCODE is simply both fields zero.
    localparam logic [3:0] DEST_IR = 4'h0;
    localparam logic [3:0] SRC_ROM = 4'h0;

    typedef enum logic {
        ST_FETCH = PH_FETCH,
        ST_EXEC  = PH_EXEC
    } phase_e;

endpackage

// File: rtl/pc_counter.sv
// pc_counter: loadable, enable-able program counter that wraps modulo 2^WIDTH.
//   clk, rst      clock, asynchronous active-high reset (count <= RESET_VAL)
//   i_load        load i_load_val this edge (has priority over i_inc)
//   i_load_val    value to load
//   i_inc         increment this edge
//   o_count       current count
module pc_counter #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Counter register: load beats increment, increment wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: nic8 fetch stage. Owns PC, IR and the FETCH/EXEC phase, plus a
// sticky jump-to-self halt flag and a saturating retired-instruction counter.
//   clk, reset    clock, asynchronous active-high reset
//   bus           data bus value this cycle
//   loadBarIR     decoder: low = IR loads from bus this edge
//   assertBarRom  decoder: low = ROM drives bus (operand consumed, PC advances)
//   doJump        decoder: high = PC loads from bus this edge
//   ir            opcode to decoder (FETCH_OPCODE in FETCH, IR register in EXEC)
//   pc            ROM address
//   phaseExec     0 = FETCH, 1 = EXEC
//   halted        sticky jump-to-self flag
//   instrCount    retired instructions, saturating
module fetch_sequencer
    import nic8_pkg::*;
#(
    parameter int                    PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
    parameter int                    CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           bus,
    input  logic                 loadBarIR,
    input  logic                 assertBarRom,
    input  logic                 doJump,
    output logic [7:0]           ir,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 phaseExec,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instrCount
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    phase_e                r_phase;
    phase_e                w_phase_next;
    logic [7:0]            r_ir;
    logic [PC_WIDTH-1:0]   r_instr_addr;
    logic                  r_halted;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [PC_WIDTH-1:0]   w_pc;
    logic [PC_WIDTH-1:0]   w_bus_pc;
    logic                  w_fetch;
    logic                  w_retire;
    logic                  w_pc_load;
    logic                  w_pc_inc;
    logic                  w_halt_set;

    assign w_bus_pc = bus[PC_WIDTH-1:0];

    // Phase state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= ST_FETCH;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Next-phase and per-edge action decode. A fetch (IR load) outranks retiring the
    // current instruction, which also makes a stray doJump during a fetch harmless.
    always_comb begin
        w_phase_next = r_phase;
        w_fetch      = 1'b0;
        w_retire     = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        w_halt_set   = 1'b0;
        if (r_halted) begin
            w_phase_next = r_phase;
        end else if (!loadBarIR && (r_phase == ST_FETCH || r_ir == FETCH_OPCODE)) begin
            // Chained fetch: an EXEC of opcode 00 is itself another fetch.
            w_fetch      = 1'b1;
            w_pc_inc     = 1'b1;
            w_phase_next = ST_EXEC;
        end else if (r_phase == ST_EXEC) begin
            w_retire     = 1'b1;
            w_phase_next = ST_FETCH;
            if (doJump) begin
                w_pc_load  = 1'b1;
                w_halt_set = (w_bus_pc == r_instr_addr);
            end else begin
                w_pc_inc   = !assertBarRom;
            end
        end else begin
            w_phase_next = r_phase;
        end
    end

    // IR, instruction address, halt flag and retired counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir         <= FETCH_OPCODE;
            r_instr_addr <= RESET_PC;
            r_halted     <= 1'b0;
            r_count      <= '0;
        end else begin
            if (w_fetch) begin
                r_ir         <= bus;
                r_instr_addr <= w_pc;
            end else begin
                r_ir         <= r_ir;
                r_instr_addr <= r_instr_addr;
            end
            r_halted <= r_halted | w_halt_set;
            if (w_retire && (r_count != {CNT_WIDTH{1'b1}})) begin
                r_count <= r_count + CNT_ONE;
            end else begin
                r_count <= r_count;
            end
        end
    end

    pc_counter #(
        .WIDTH     (PC_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_pc_load),
        .i_load_val (w_bus_pc),
        .i_inc      (w_pc_inc),
        .o_count    (w_pc)
    );

    assign ir         = (r_phase == ST_EXEC) ? r_ir : FETCH_OPCODE;
    assign pc         = w_pc;
    assign phaseExec  = r_phase;
    assign halted     = r_halted;
    assign instrCount = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bus;
    logic        loadBarIR;
    logic        assertBarRom;
    logic        doJump;
    logic [7:0]  ir;
    logic [7:0]  pc;
    logic        phaseExec;
    logic        halted;
    logic [15:0] instrCount;
    logic [7:0]  s_ir;
    logic [7:0]  s_pc;
    logic        s_phase;
    logic        s_halted;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .loadBarIR(loadBarIR),
        .assertBarRom(assertBarRom), .doJump(doJump), .ir(ir), .pc(pc),
        .phaseExec(phaseExec), .halted(halted), .instrCount(instrCount)
    );

    // Small counter and non-zero reset PC to reach saturation quickly.
    fetch_sequencer #(.PC_WIDTH(8), .RESET_PC(8'hF0), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .reset(reset), .bus(bus), .loadBarIR(loadBarIR),
        .assertBarRom(assertBarRom), .doJump(doJump), .ir(s_ir), .pc(s_pc),
        .phaseExec(s_phase), .halted(s_halted), .instrCount(s_cnt)
    );

    typedef struct {
        string      name;
        logic       lbir;
        logic       abr;
        logic       dj;
        logic [7:0] bus;
        logic [7:0] e_ir;
        logic [7:0] e_pc;
        logic       e_ph;
        logic       e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_main(input string name, input logic [7:0] e_ir, input logic [7:0] e_pc,
                              input logic e_ph, input logic e_halt, input logic [15:0] e_cnt);
        check({name, ".ir"}, {24'h0, ir}, {24'h0, e_ir});
        check({name, ".pc"}, {24'h0, pc}, {24'h0, e_pc});
        check({name, ".phase"}, {31'h0, phaseExec}, {31'h0, e_ph});
        check({name, ".halted"}, {31'h0, halted}, {31'h0, e_halt});
        check({name, ".count"}, {16'h0, instrCount}, {16'h0, e_cnt});
    endtask

    task automatic drive(input logic lbir, input logic abr, input logic dj, input logic [7:0] b);
        loadBarIR    = lbir;
        assertBarRom = abr;
        doJump       = dj;
        bus          = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            name       lbir  abr   dj    bus    ir     pc     ph    halt  cnt
        vecs[0]  = '{"fetch42",  1'b0, 1'b1, 1'b0, 8'h42, 8'h42, 8'h01, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{"imm",      1'b1, 1'b0, 1'b0, 8'h99, 8'h00, 8'h02, 1'b0, 1'b0, 16'd1};
        vecs[2]  = '{"fetchA5",  1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 8'h03, 1'b1, 1'b0, 16'd1};
        vecs[3]  = '{"jump80",   1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0, 16'd2};
        vecs[4]  = '{"fetch00",  1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h81, 1'b1, 1'b0, 16'd2};
        vecs[5]  = '{"chain00",  1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h82, 1'b1, 1'b0, 16'd2};
        vecs[6]  = '{"chain37",  1'b0, 1'b1, 1'b0, 8'h37, 8'h37, 8'h83, 1'b1, 1'b0, 16'd2};
        vecs[7]  = '{"exechold", 1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 8'h83, 1'b0, 1'b0, 16'd3};
        vecs[8]  = '{"fetchidl", 1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 8'h83, 1'b0, 1'b0, 16'd3};
        vecs[9]  = '{"illegal",  1'b0, 1'b1, 1'b1, 8'h11, 8'h11, 8'h84, 1'b1, 1'b0, 16'd3};
        vecs[10] = '{"jumpFF",   1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 16'd4};
        vecs[11] = '{"wrap",     1'b0, 1'b1, 1'b0, 8'h22, 8'h22, 8'h00, 1'b1, 1'b0, 16'd4};
        vecs[12] = '{"jump10",   1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 8'h10, 1'b0, 1'b0, 16'd5};
        vecs[13] = '{"fetch@10", 1'b0, 1'b1, 1'b0, 8'hC0, 8'hC0, 8'h11, 1'b1, 1'b0, 16'd5};
        vecs[14] = '{"halt",     1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 8'h10, 1'b0, 1'b1, 16'd6};

        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        step();
        step();
        check_main("reset", 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].lbir, vecs[i].abr, vecs[i].dj, vecs[i].bus);
            step();
            check_main(vecs[i].name, vecs[i].e_ir, vecs[i].e_pc, vecs[i].e_ph,
                       vecs[i].e_halt, vecs[i].e_cnt);
        end

        // Frozen while halted, whatever the decoder does.
        for (int i = 0; i < 10; i++) begin
            case (i % 3)
                0:       drive(1'b0, 1'b1, 1'b0, 8'h55);
                1:       drive(1'b1, 1'b1, 1'b1, 8'h20);
                default: drive(1'b1, 1'b0, 1'b0, 8'h33);
            endcase
            step();
            check_main("frozen", 8'h00, 8'h10, 1'b0, 1'b1, 16'd6);
        end

        // Async reset between edges clears the sticky halt immediately.
        #2 reset = 1'b1;
        #1 check_main("rst_halted", 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        drive(1'b0, 1'b1, 1'b0, 8'h42);
        step();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b1, 1'b0, 8'h33);
        step();
        check_main("pre_rst", 8'h33, 8'h03, 1'b1, 1'b0, 16'd1);
        drive(1'b1, 1'b0, 1'b1, 8'h77);
        #2 reset = 1'b1;
        #1 check_main("rst_exec", 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
        check("small_rst.pc", {24'h0, s_pc}, 32'h0000_00F0);
        check("small_rst.cnt", {30'h0, s_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Saturating counter on the narrow instance; PC counts up from F0.
        for (int k = 0; k < 5; k++) begin
            logic [7:0] e_pc;
            logic [1:0] e_cnt;
            drive(1'b0, 1'b1, 1'b0, 8'hA0);
            step();
            e_pc = 8'hF0 + 8'(2 * k + 1);
            check("small_fetch.pc", {24'h0, s_pc}, {24'h0, e_pc});
            check("small_fetch.ir", {24'h0, s_ir}, 32'h0000_00A0);
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            step();
            e_pc  = 8'hF0 + 8'(2 * k + 2);
            e_cnt = (k >= 2) ? 2'd3 : 2'(k + 1);
            check("small_imm.pc", {24'h0, s_pc}, {24'h0, e_pc});
            check("small_imm.cnt", {30'h0, s_cnt}, {30'h0, e_cnt});
            check("small_imm.phase", {31'h0, s_phase}, 32'h0);
        end
        check("small.halted", {31'h0, s_halted}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
